dmem_responder: RTL and testbench

//  Responder end of the core's load/store port: a word-organised data memory serving one

---
 rtl/dmem_pkg.sv | 22 ++
 rtl/dmem_lane_steer.sv | 54 +++++
 rtl/dmem_responder.sv | 121 ++++++++++++
 tb/tb_dmem_responder.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the handshaked data memory: funct3 codes, FSM states,
// and the alignment rule used by both the top and the lane steering.
package dmem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   // Halfwords need an even offset, words need offset 0; bytes never fault.
   function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
      case (funct3)
         F3_H, F3_HU: return off[0];
         F3_W:        return off != 2'b00;
         default:     return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/dmem_lane_steer.sv
// Combinational byte-lane steering: store byte enables/replicated write word,
// load lane extraction with sign/zero extension, and funct3 legality.
module dmem_lane_steer
   import dmem_pkg::*;
(
   input  logic        we,
   input  logic [2:0]  funct3,
   input  logic [1:0]  off,
   input  logic [31:0] wdata,
   input  logic [31:0] rword,
   output logic [3:0]  byte_en,
   output logic [31:0] wword,
   output logic [31:0] load_data,
   output logic        illegal
);

   logic [31:0] shifted;

   // Bring the addressed lane down to bit 0 so extraction is size-only.
   assign shifted = rword >> {off, 3'b000};

   always_comb begin
      byte_en   = 4'b0000;
      wword     = wdata;
      load_data = 32'h0;
      illegal   = 1'b0;
      case (funct3)
         F3_B: begin
            byte_en   = 4'b0001 << off;
            wword     = {4{wdata[7:0]}};
            load_data = {{24{shifted[7]}}, shifted[7:0]};
         end
         F3_H: begin
            byte_en   = off[1] ? 4'b1100 : 4'b0011;
            wword     = {2{wdata[15:0]}};
            load_data = {{16{shifted[15]}}, shifted[15:0]};
         end
         F3_W: begin
            byte_en   = 4'b1111;
            load_data = shifted;
         end
         F3_BU: begin
            illegal   = we;
            load_data = {24'h0, shifted[7:0]};
         end
         F3_HU: begin
            illegal   = we;
            load_data = {16'h0, shifted[15:0]};
         end
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// Word-organised data memory behind valid/ready request and response channels,
// one access at a time with WAIT_CYCLES wait states before the access.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned WAIT_CYCLES = 2,
   parameter logic [31:0] BASE_ADDR   = 32'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [2:0]  req_funct3,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

   state_t        state;
   logic [CW-1:0] cnt;
   logic          we_q;
   logic [31:0]   addr_q;
   logic [31:0]   wdata_q;
   logic [2:0]    f3_q;

   logic [31:0]   mem [DEPTH_WORDS];

   logic [31:0]   offs;
   logic [AW-1:0] widx;
   logic [31:0]   rword;
   logic [3:0]    byte_en;
   logic [31:0]   wword;
   logic [31:0]   load_data;
   logic          illegal;
   logic          misaligned;
   logic          out_of_range;
   logic          err;
   logic          perform;

   // A base above the address wraps the subtraction; the explicit compare catches it too.
   assign offs         = addr_q - BASE_ADDR;
   assign widx         = offs[AW+1:2];
   assign out_of_range = (addr_q < BASE_ADDR) || (32'(offs[31:2]) >= DEPTH_WORDS);
   assign misaligned   = is_misaligned(f3_q, offs[1:0]);
   assign err          = illegal | misaligned | out_of_range;
   assign rword        = mem[widx];
   assign perform      = (state == BUSY) && (cnt == '0);

   assign req_ready = (state == IDLE);
   assign rsp_valid = (state == RESP);

   dmem_lane_steer u_steer (
      .we        (we_q),
      .funct3    (f3_q),
      .off       (offs[1:0]),
      .wdata     (wdata_q),
      .rword     (rword),
      .byte_en   (byte_en),
      .wword     (wword),
      .load_data (load_data),
      .illegal   (illegal)
   );

   // No reset on the array: contents survive reset. Writes only happen from BUSY,
   // which reset forces away asynchronously, so an interrupted store never lands.
   always_ff @(posedge clk) begin
      if (perform && we_q && !err) begin
         for (int b = 0; b < 4; b++) begin
            if (byte_en[b]) mem[widx][8*b +: 8] <= wword[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         cnt       <= '0;
         we_q      <= 1'b0;
         addr_q    <= 32'h0;
         wdata_q   <= 32'h0;
         f3_q      <= 3'b000;
         rsp_rdata <= 32'h0;
         rsp_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  we_q    <= req_we;
                  addr_q  <= req_addr;
                  wdata_q <= req_wdata;
                  f3_q    <= req_funct3;
                  cnt     <= CW'(WAIT_CYCLES);
                  state   <= BUSY;
               end
            end
            BUSY: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  rsp_rdata <= (err || we_q) ? 32'h0 : load_data;
                  rsp_err   <= err;
                  state     <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: byte-array reference model checked every cycle,
// plus directed transactions with hand-computed literal results.
module tb_dmem_responder;

   localparam int          DEPTH = 1024;
   localparam int          W     = 2;
   localparam logic [31:0] BASE  = 32'h0;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_we;
   logic [31:0] req_addr, req_wdata;
   logic [2:0]  req_funct3;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_rdata;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W), .BASE_ADDR(BASE)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_funct3 (req_funct3),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // ---------------- reference model (byte-addressed memory) ----------------
   logic [7:0]  bmem [0:4*DEPTH-1];
   bit          outstanding = 0;
   int          acc;
   logic        m_we;
   logic [31:0] m_addr, m_wdata;
   logic [2:0]  m_f3;
   logic [31:0] exp_rd;
   logic        exp_er;

   task automatic model_access();
      int nb;
      logic ill, mis, oor;
      logic [31:0] v;
      ill = m_we ? (m_f3 > 3'd2) : (m_f3 == 3'd3 || m_f3 > 3'd5);
      nb  = 1 << m_f3[1:0];
      mis = (int'(m_addr[2:0]) % nb) != 0;
      oor = (m_addr < BASE) || (longint'(m_addr) - longint'(BASE) >= 4 * DEPTH);
      v   = 32'h0;
      if (ill || mis || oor) begin
         exp_er = 1'b1;
      end else if (m_we) begin
         exp_er = 1'b0;
         for (int i = 0; i < nb; i++) bmem[m_addr - BASE + i] = m_wdata[8*i +: 8];
      end else begin
         exp_er = 1'b0;
         for (int i = 0; i < nb; i++) v[8*i +: 8] = bmem[m_addr - BASE + i];
         if (m_f3 < 3'd4 && nb < 4 && v[8*nb-1])
            for (int j = 8 * nb; j < 32; j++) v[j] = 1'b1;
      end
      exp_rd = v;
   endtask

   always @(negedge clk) begin
      bit exp_v;
      if (!rst) begin
         outstanding = 0;
         chk("rst_req_ready", req_ready, 1);
         chk("rst_rsp_valid", rsp_valid, 0);
         chk("rst_rsp_rdata", rsp_rdata, 0);
         chk("rst_rsp_err",   rsp_err,   0);
      end else begin
         if (outstanding && cyc == acc + W + 1) model_access();
         exp_v = outstanding && (cyc >= acc + W + 1);
         chk("req_ready", req_ready, !outstanding);
         chk("rsp_valid", rsp_valid, exp_v);
         if (exp_v) begin
            chk("rsp_rdata", rsp_rdata, exp_rd);
            chk("rsp_err",   rsp_err,   exp_er);
         end
         if (exp_v && rsp_ready) begin
            outstanding = 0;
         end else if (!outstanding && req_valid) begin
            m_we = req_we; m_addr = req_addr; m_wdata = req_wdata; m_f3 = req_funct3;
            acc = cyc + 1;
            outstanding = 1;
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic do_req(input logic we, input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] f3, output logic [31:0] rd, output logic er,
                         output int lat);
      int n;
      @(posedge clk); #1;
      req_we = we; req_addr = a; req_wdata = d; req_funct3 = f3;
      req_valid = 1'b1; rsp_ready = 1'b1;
      n = 0;
      while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 0;
      while (!rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
      if (!rsp_valid) chk("rsp_timeout", 0, 1);
      rd = rsp_rdata; er = rsp_err;
      @(posedge clk); #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] rd;
      logic        er;
      int          lat, n;

      rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0;
      req_wdata = 32'h0; req_funct3 = 3'b000; rsp_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      chk("t1_req_ready", req_ready, 1);
      chk("t1_rsp_valid", rsp_valid, 0);
      chk("t1_rsp_rdata", rsp_rdata, 0);
      chk("t1_rsp_err",   rsp_err,   0);

      // word store then load, with latency
      do_req(1, 32'h10, 32'hDEADBEEF, 3'b010, rd, er, lat);
      chk("t2_sw_rdata", rd, 0); chk("t2_sw_err", er, 0); chk("t2_sw_lat", lat, 3);
      do_req(0, 32'h10, 32'h0, 3'b010, rd, er, lat);
      chk("t2_lw_rdata", rd, 32'hDEADBEEF); chk("t2_lw_err", er, 0); chk("t2_lw_lat", lat, 3);

      // byte store and sub-word loads
      do_req(1, 32'h13, 32'h00000080, 3'b000, rd, er, lat);
      chk("t3_sb_err", er, 0);
      do_req(0, 32'h13, 32'h0, 3'b000, rd, er, lat); chk("t3_lb",  rd, 32'hFFFFFF80);
      do_req(0, 32'h13, 32'h0, 3'b100, rd, er, lat); chk("t3_lbu", rd, 32'h00000080);
      do_req(0, 32'h10, 32'h0, 3'b010, rd, er, lat); chk("t3_lw",  rd, 32'h80ADBEEF);
      do_req(0, 32'h12, 32'h0, 3'b001, rd, er, lat); chk("t3_lh",  rd, 32'hFFFF80AD);
      do_req(0, 32'h12, 32'h0, 3'b101, rd, er, lat); chk("t3_lhu", rd, 32'h000080AD);

      // errors; memory must be untouched afterwards
      do_req(1, 32'h11, 32'hFFFF, 3'b001, rd, er, lat);
      chk("t4_sh_mis_err", er, 1); chk("t4_sh_mis_rdata", rd, 0);
      do_req(0, 32'h1000, 32'h0, 3'b010, rd, er, lat);
      chk("t4_oor_err", er, 1); chk("t4_oor_rdata", rd, 0);
      do_req(0, 32'h10, 32'h0, 3'b011, rd, er, lat);
      chk("t4_ill_err", er, 1); chk("t4_ill_rdata", rd, 0);
      do_req(1, 32'h10, 32'h11111111, 3'b100, rd, er, lat);
      chk("t4_ill_st_err", er, 1);
      do_req(0, 32'h10, 32'h0, 3'b010, rd, er, lat);
      chk("t4_lw_rdata", rd, 32'h80ADBEEF); chk("t4_lw_err", er, 0);
      // last word in range
      do_req(1, 32'hFFC, 32'hCAFEF00D, 3'b010, rd, er, lat); chk("t4_sw_top_err", er, 0);
      do_req(0, 32'hFFC, 32'h0, 3'b010, rd, er, lat);        chk("t4_lw_top", rd, 32'hCAFEF00D);

      // backpressure: response held, second request waits
      @(posedge clk); #1;
      req_we = 1'b0; req_addr = 32'h10; req_funct3 = 3'b010; req_valid = 1'b1; rsp_ready = 1'b0;
      @(posedge clk); #1;
      req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h0BADF00D; req_funct3 = 3'b010;
      n = 0;
      while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
      chk("t5_first_valid", rsp_valid, 1);
      repeat (5) begin
         @(posedge clk); #1;
         chk("t5_hold_valid", rsp_valid, 1);
         chk("t5_hold_rdata", rsp_rdata, 32'h80ADBEEF);
         chk("t5_hold_ready", req_ready, 0);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      chk("t5_idle_after", req_ready, 1);
      chk("t5_valid_drop", rsp_valid, 0);
      @(posedge clk); #1;
      req_valid = 1'b0;
      n = 0;
      while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
      chk("t5_second_lat", n, 3);
      chk("t5_second_err", rsp_err, 0);
      @(posedge clk); #1;

      // reset during BUSY abandons the store
      @(posedge clk); #1;
      req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678; req_funct3 = 3'b010;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      chk("t6_ready", req_ready, 1);
      chk("t6_valid", rsp_valid, 0);
      repeat (4) @(posedge clk);
      #1;
      do_req(0, 32'h20, 32'h0, 3'b010, rd, er, lat);
      chk("t6_lw_rdata", rd, 32'h0BADF00D); chk("t6_lw_err", er, 0);

      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
